// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encodings and
// the byte-offset mask used for misaligned-access detection.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_RDONE = 2'd3
  } state_e;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_bridge_wbuf.sv
// Single-entry store buffer for the data-memory bridge: captures a store,
// retires it when the bus drain completes, and flags word-address matches.
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_i,
  input  logic             retire_i,
  input  logic [WIDTH-1:2] addr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:2] lookup_i,
  output logic             valid_o,
  output logic [WIDTH-1:2] addr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             match_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:2] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A capture in the same cycle as a retire keeps the entry occupied.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (retire_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign match_o = valid_q && (lookup_i == addr_q);

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: buffers stores, forwards buffered data to
// matching loads, and stalls the pipeline while a load misses on the bus.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memreadM,
  input  logic             memwriteM,
  input  logic [WIDTH-1:0] aluoutM,
  input  logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] readdataM,
  output logic             stallM,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic [WIDTH-1:0] bus_rdata,
  input  logic             bus_ack,
  output logic             misalign_err
);

  state_e           state_q;
  logic             busReq_q;
  logic             busWe_q;
  logic [WIDTH-1:0] busAddr_q;
  logic [WIDTH-1:0] busWdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             misalign_q;

  logic             isLoad;
  logic             isStore;
  logic             misalignNow;
  logic             ackValid;
  logic             drainAck;
  logic             storeAccept;
  logic             loadHit;
  logic             wbValid;
  logic             wbMatch;
  logic [WIDTH-1:2] wbAddr;
  logic [WIDTH-1:0] wbData;
  logic [WIDTH-1:2] wordAddr;

  // A simultaneous read+write request is handled as a store.
  assign isStore     = memwriteM;
  assign isLoad      = memreadM && !memwriteM;
  assign wordAddr    = aluoutM[WIDTH-1:2];
  assign misalignNow = (memreadM || memwriteM) &&
                       (((aluoutM[1:0] & MISALIGN_MASK) != 2'b00) || (memreadM && memwriteM));
  assign ackValid    = bus_ack && busReq_q;
  assign drainAck    = ackValid && (state_q == ST_WR);
  assign storeAccept = !reset && isStore && (!wbValid || drainAck);
  assign loadHit     = isLoad && wbMatch;

  dmem_wbuf #(.WIDTH(WIDTH)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .capture_i (storeAccept),
    .retire_i  (drainAck),
    .addr_i    (wordAddr),
    .data_i    (writedataM),
    .lookup_i  (wordAddr),
    .valid_o   (wbValid),
    .addr_o    (wbAddr),
    .data_o    (wbData),
    .match_o   (wbMatch)
  );

  always_comb begin
    stallM = 1'b0;
    if (!reset) begin
      if (isStore && wbValid && !drainAck) begin
        stallM = 1'b1;
      end else if (isLoad && !loadHit && (state_q != ST_RDONE)) begin
        stallM = 1'b1;
      end
    end
  end

  always_comb begin
    readdataM = '0;
    if (!reset) begin
      if (loadHit) begin
        readdataM = wbData;
      end else if (state_q == ST_RDONE) begin
        readdataM = rdata_q;
      end
    end
  end

  // Draining the store buffer always takes priority over starting a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busReq_q   <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (misalignNow) begin
        misalign_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (wbValid) begin
            state_q    <= ST_WR;
            busReq_q   <= 1'b1;
            busWe_q    <= 1'b1;
            busAddr_q  <= {wbAddr, 2'b00};
            busWdata_q <= wbData;
          end else if (isLoad) begin
            state_q   <= ST_RD;
            busReq_q  <= 1'b1;
            busWe_q   <= 1'b0;
            busAddr_q <= {wordAddr, 2'b00};
          end
        end
        ST_WR: begin
          if (ackValid) begin
            state_q  <= ST_IDLE;
            busReq_q <= 1'b0;
            busWe_q  <= 1'b0;
          end
        end
        ST_RD: begin
          if (ackValid) begin
            state_q  <= ST_RDONE;
            busReq_q <= 1'b0;
            rdata_q  <= bus_rdata;
          end
        end
        ST_RDONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req      = busReq_q;
  assign bus_we       = busWe_q;
  assign bus_addr     = busAddr_q;
  assign bus_wdata    = busWdata_q;
  assign misalign_err = misalign_q;

endmodule
